// File: rtl/halut_pkg.sv
// halut_pkg: shared types and helpers for the HALUT encoder.
//   fp16_t      - raw FP16 bit pattern
//   node_idx_t  - heap node index / prototype index for the default tree depth
//   heap_child  - heap-order child of a node for a given decision
//   leaf_to_k   - heap leaf index to prototype index
package halut_pkg;

    localparam int unsigned HalutK     = 16;
    localparam int unsigned HalutC     = 32;
    localparam int unsigned FpWidth    = 16;
    localparam int unsigned HalutDepth = $clog2(HalutK);

    typedef logic [FpWidth-1:0]    fp16_t;
    typedef logic [HalutDepth-1:0] node_idx_t;

    // Left child is 2n+1, right child is 2n+2.
    function automatic int unsigned heap_child(input int unsigned node, input logic go_right);
        return 2 * node + 1 + 32'(go_right);
    endfunction

    // Leaves of a K-prototype tree start at heap index K-1.
    function automatic int unsigned leaf_to_k(input int unsigned leaf, input int unsigned k);
        return leaf - (k - 1);
    endfunction

endpackage

// File: rtl/halut_encoder_fp16_gt.sv
// fp16_gt: combinational strict FP16 greater-than (i_a > i_b).
//   i_a  - left operand (feature value)
//   i_b  - right operand (threshold)
//   o_gt - 1 when i_a > i_b; 0 on equality, +0 vs -0, or any NaN operand
module fp16_gt
    import halut_pkg::*;
(
    input  fp16_t i_a,
    input  fp16_t i_b,
    output logic  o_gt
);

    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_both_zero;
    logic [14:0] w_a_mag;
    logic [14:0] w_b_mag;

    assign w_a_mag     = i_a[14:0];
    assign w_b_mag     = i_b[14:0];
    assign w_a_nan     = (&i_a[14:10]) && (|i_a[9:0]);
    assign w_b_nan     = (&i_b[14:10]) && (|i_b[9:0]);
    assign w_both_zero = (w_a_mag == 15'd0) && (w_b_mag == 15'd0);

    always_comb begin
        o_gt = 1'b0;
        if (w_a_nan || w_b_nan || w_both_zero) begin
            o_gt = 1'b0;
        end else if (i_a[15] != i_b[15]) begin
            // Signs differ and not both zero: a wins only when b is the negative one.
            o_gt = i_b[15];
        end else if (i_a[15]) begin
            o_gt = (w_a_mag < w_b_mag);
        end else begin
            o_gt = (w_a_mag > w_b_mag);
        end
    end

endmodule

// File: rtl/halut_encoder.sv
// halut_encoder: walks one balanced decision tree per codebook per row and emits
// the prototype index of each codebook to the downstream halut_decoder.
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   thr_waddr_i/wdata_i/we_i        - threshold write port, address {c, node}
//   in_valid_i/in_data_i/in_ready_o - one FP16 feature per (codebook, level) beat
//   c_addr_o, k_addr_o              - codebook and prototype of the last result
//   decoder_o                       - one-cycle strobe for a new result
//   row_last_o                      - with decoder_o on the last codebook of a row
module halut_encoder
    import halut_pkg::*;
#(
    parameter int unsigned K             = HalutK,
    parameter int unsigned C             = HalutC,
    parameter int unsigned DataTypeWidth = FpWidth,
    parameter int unsigned TreeDepth     = $clog2(K),
    parameter int unsigned CAddrWidth    = $clog2(C),
    parameter int unsigned ThrAddrWidth  = CAddrWidth + TreeDepth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ThrAddrWidth-1:0]  thr_waddr_i,
    input  logic [DataTypeWidth-1:0] thr_wdata_i,
    input  logic                     thr_we_i,
    input  logic                     in_valid_i,
    input  logic [DataTypeWidth-1:0] in_data_i,
    output logic                     in_ready_o,
    output logic [CAddrWidth-1:0]    c_addr_o,
    output logic [TreeDepth-1:0]     k_addr_o,
    output logic                     decoder_o,
    output logic                     row_last_o
);

    localparam int unsigned LvlWidth = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;
    localparam int unsigned NumNodes = K - 1;

    // Threshold store: not reset, contents survive rst_i.
    logic [DataTypeWidth-1:0] r_thr [C][NumNodes];

    logic [LvlWidth-1:0]   r_lvl,    w_lvl_d;
    logic [CAddrWidth-1:0] r_cb,     w_cb_d;
    logic [TreeDepth-1:0]  r_node,   w_node_d;
    logic [TreeDepth-1:0]  r_dec,    w_dec_d;
    logic [CAddrWidth-1:0] r_c_addr, w_c_addr_d;
    logic [TreeDepth-1:0]  r_k_addr, w_k_addr_d;
    logic                  r_decoder, w_decoder_d;
    logic                  r_row_last, w_row_last_d;

    logic [CAddrWidth-1:0]    w_wr_c;
    logic [TreeDepth-1:0]     w_wr_node;
    logic [DataTypeWidth-1:0] w_thr;
    logic                     w_gt;
    logic                     w_accept;
    logic                     w_last_lvl;
    logic                     w_last_cb;

    assign w_wr_c    = thr_waddr_i[ThrAddrWidth-1:TreeDepth];
    assign w_wr_node = thr_waddr_i[TreeDepth-1:0];

    always_ff @(posedge clk_i) begin
        // Node K-1 would be a leaf; writes to it are dropped.
        if (thr_we_i && (w_wr_node != TreeDepth'(NumNodes))) begin
            r_thr[w_wr_c][w_wr_node] <= thr_wdata_i;
        end
    end

    assign w_thr = r_thr[r_cb][r_node];

    fp16_gt u_fp16_gt (
        .i_a  (in_data_i),
        .i_b  (w_thr),
        .o_gt (w_gt)
    );

    // A threshold write owns the cycle, so a stalled beat sees the new value.
    assign in_ready_o = !thr_we_i && !rst_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_last_lvl = (r_lvl == LvlWidth'(TreeDepth - 1));
    assign w_last_cb  = (r_cb == CAddrWidth'(C - 1));

    always_comb begin
        w_lvl_d      = r_lvl;
        w_cb_d       = r_cb;
        w_node_d     = r_node;
        w_dec_d      = r_dec;
        w_c_addr_d   = r_c_addr;
        w_k_addr_d   = r_k_addr;
        w_decoder_d  = 1'b0;
        w_row_last_d = 1'b0;
        if (w_accept) begin
            if (!w_last_lvl) begin
                w_node_d = TreeDepth'(heap_child(32'(r_node), w_gt));
                w_dec_d  = TreeDepth'({r_dec, w_gt});
                w_lvl_d  = r_lvl + LvlWidth'(1);
            end else begin
                // Earlier decisions form the MSBs, level 0 first.
                w_k_addr_d   = TreeDepth'({r_dec, w_gt});
                w_c_addr_d   = r_cb;
                w_decoder_d  = 1'b1;
                w_row_last_d = w_last_cb;
                w_node_d     = '0;
                w_dec_d      = '0;
                w_lvl_d      = '0;
                w_cb_d       = w_last_cb ? '0 : r_cb + CAddrWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lvl      <= '0;
            r_cb       <= '0;
            r_node     <= '0;
            r_dec      <= '0;
            r_c_addr   <= '0;
            r_k_addr   <= '0;
            r_decoder  <= 1'b0;
            r_row_last <= 1'b0;
        end else begin
            r_lvl      <= w_lvl_d;
            r_cb       <= w_cb_d;
            r_node     <= w_node_d;
            r_dec      <= w_dec_d;
            r_c_addr   <= w_c_addr_d;
            r_k_addr   <= w_k_addr_d;
            r_decoder  <= w_decoder_d;
            r_row_last <= w_row_last_d;
        end
    end

    assign c_addr_o   = r_c_addr;
    assign k_addr_o   = r_k_addr;
    assign decoder_o  = r_decoder;
    assign row_last_o = r_row_last;

endmodule

// File: doc/halut_encoder.md
# halut_encoder

Upstream stage of `halut_decoder`: per input row, walks one balanced binary decision tree per codebook and emits the prototype index (`k_addr`) for each codebook in order `c = 0..C-1`. Each tree step is a strict FP16 greater-than test of one feature value against a stored per-node threshold. The encoder's `c_addr_o`, `k_addr_o` and `decoder_o` drive the decoder's `c_addr_i`, `k_addr_i` and `decoder_i` directly. Thresholds are programmed through a write port, as the decoder LUT is.

## Interface
- `K`, 16: prototypes per codebook; power of two, ≥ 2.
- `C`, 32: codebooks per row.
- `DataTypeWidth`, 16: feature and threshold width; fixed FP16.
- `TreeDepth`, `$clog2(K)`: tree levels; beats per codebook.
- `CAddrWidth`, `$clog2(C)`: codebook index width.
- `ThrAddrWidth`, `CAddrWidth+TreeDepth`: threshold address `{c, node}`.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `thr_waddr_i`  in  ThrAddrWidth  threshold write address `{c, node}`.
- `thr_wdata_i`  in  DataTypeWidth  FP16 threshold.
- `thr_we_i`  in  1  threshold write enable.
- `in_valid_i`  in  1  feature beat valid.
- `in_data_i`  in  DataTypeWidth  FP16 feature value for the current `(c, level)`.
- `in_ready_o`  out  1  beat accepted when `in_valid_i && in_ready_o`.
- `c_addr_o`  out  CAddrWidth  codebook of the last emitted result.
- `k_addr_o`  out  TreeDepth  prototype index of the last emitted result.
- `decoder_o`  out  1  one-cycle strobe: new `c_addr_o`/`k_addr_o` are valid.
- `row_last_o`  out  1  asserted with `decoder_o` when `c_addr_o == C-1`.

## Operation
Threshold store:
- Holds `C × (K-1)` entries.
- Node numbering is heap order: root 0; children of node `n` are `2n+1` (left) and `2n+2` (right).
- A write to node `K-1` is ignored.
- Entries are not reset. Contents are undefined until written and are retained across `rst_i`.

Beat order:
- `TreeDepth` beats per codebook, level 0 first.
- Codebooks in order 0..C-1.
- `C·TreeDepth` beats per row.

State:
- Level counter `lvl`, `0..TreeDepth-1`.
- Codebook counter `cb`, `0..C-1`.
- Node register `node`, `TreeDepth` bits.
- Decision shift register `dec`, `TreeDepth` bits.

Per accepted beat:
- Compute `gt = fp16_gt(in_data_i, thr[cb][node])`.
- If `lvl < TreeDepth-1`: `node <= 2·node + 1 + gt`, shift `gt` into `dec` (LSB side), `lvl <= lvl + 1`.
- If `lvl == TreeDepth-1`: emit `k = {dec, gt}`. MSB is the level-0 decision. This equals `final_leaf - (K-1)`.
- After emitting: clear `node`, `dec` and `lvl`; `cb` wraps `C-1 → 0`.

FP16 greater-than:
- Strict. Equality goes left.
- `+0` and `-0` are equal.
- Sign-magnitude ordering, so a negative value is never greater than a positive one.
- If either operand is NaN, the result is 0 (go left).

Handshake:
- `in_ready_o = !thr_we_i`. A threshold write takes priority and stalls the input stream for that cycle.
- Without an accepted beat, no state advances.
- Gaps between beats are allowed at any level.

Reset (`rst_i` high, including mid-row):
- `lvl`, `cb`, `node` and `dec` return to 0. A partially walked tree is discarded.
- `decoder_o = 0`, `row_last_o = 0`, `c_addr_o = 0`, `k_addr_o = 0`.
- `in_ready_o = 0` while `rst_i` is high.

## Timing
- Threshold read is combinational from the register array. The compare and the next-node update complete in the cycle of acceptance.
- A final-level beat accepted in cycle t produces `decoder_o = 1` in cycle t+1, with `c_addr_o`, `k_addr_o` and `row_last_o` valid in that same cycle.
- `decoder_o` and `row_last_o` are single-cycle pulses.
- `c_addr_o` and `k_addr_o` hold their value until the next emit.
- A threshold write takes effect for compares from cycle t+1. A write issued in the same cycle as a beat stalls that beat, so the beat compares against the new value.
- Peak throughput: one result per `TreeDepth` cycles.

## Structure
- `halut_pkg` holds:
  - `fp16_t` typedef;
  - a `node_idx_t` typedef sized to `TreeDepth`;
  - helper functions for heap child and leaf-to-k conversion.
- Sub-module `fp16_gt`: purely combinational FP16 strict greater-than with the NaN and ±0 rules above. It is instantiated once.
- The threshold store, counters and output registers stay in `halut_encoder`.

## Test plan
All scenarios use defaults K=16, C=32.
- Directed paths, codebook 0, all 15 thresholds = `0x3C00` (1.0):
  - four beats of `0x4000` → `decoder_o` one cycle after the 4th beat, `c_addr_o = 0`, `k_addr_o = 15`;
  - four beats of `0x3800` → `k_addr_o = 0`.
- Mixed path, same thresholds: beats `0x4000, 0x3800, 0x4000, 0x3800` → nodes visited 0→2→5→12, `k_addr_o = 10`.
- Edge compares, all on one level 0 with thresholds set per case:
  - value = threshold `0x3C00` → left;
  - `0x8000` vs threshold `0x0000` → left;
  - `0xBC00` (-1.0) vs threshold `0xC000` (-2.0) → right;
  - `0x7E00` (NaN) → left.
- Full row: 128 beats, with random gaps on `in_valid_i` → exactly 32 `decoder_o` pulses, `c_addr_o` running 0..31, `row_last_o` only on the 32nd. The next row restarts at `c_addr_o = 0`.
- Write priority: assert `thr_we_i` in the same cycle as `in_valid_i` → `in_ready_o = 0`, the beat is held, and the beat then uses the newly written threshold.
- Reset mid-tree: assert `rst_i` after 2 beats of codebook 5 → outputs go to 0, and the next four beats produce `c_addr_o = 0` from a root-level walk.
